// File: rtl/tr_step_tracker_if.sv
// Signal bundle between ADC capture, the step tracker and the stepper driver pins.
// Optional step_pos lane exists only when STEP_COUNT_EN is defined.
interface tr_step_tracker_if #(
  parameter int W = 12
);
  logic [W-1:0]       x;
  logic [W-1:0]       x0;
  logic [W-1:0]       dx1;
  logic [W-1:0]       dx2;
  logic               data_valid;
  logic               tr_mode_enable;
  logic               drv_enable_SM;
  logic               drv_step;
  logic               drv_dir;
  logic               pulse;
  logic [1:0]         zone;
  logic               busy;
`ifdef STEP_COUNT_EN
  logic signed [31:0] step_pos;
`endif

  modport master (
    output x, x0, dx1, dx2, data_valid, tr_mode_enable,
`ifdef STEP_COUNT_EN
    input  step_pos,
`endif
    input  drv_enable_SM, drv_step, drv_dir, pulse, zone, busy
  );

  modport slave (
    input  x, x0, dx1, dx2, data_valid, tr_mode_enable,
`ifdef STEP_COUNT_EN
    output step_pos,
`endif
    output drv_enable_SM, drv_step, drv_dir, pulse, zone, busy
  );
endinterface

// File: rtl/tr_step_tracker.sv
// Tracking regulator: steps a stepper driver so ADC sample x follows x0 (optional STEP_COUNT_EN adds step_pos).
// Latency: zone/sign register one cycle after a valid sample; a step starts >= DIR_SETUP+1 cycles after a dir change.
// Backpressure: none; data_valid samples are taken every cycle, step rate bounded by the latched zone period.
module tr_step_tracker #(
  parameter int W            = 12,
  parameter int PULSE_W      = 2,
  parameter int DIR_SETUP    = 4,
  parameter int FAST_DIV     = 500,
  parameter int SLOW_DIV     = 2000,
  parameter int HOLD_TIMEOUT = 50000
) (
  input logic              clk,
  input logic              rst,
  tr_step_tracker_if.slave bus
);

  localparam int CNT_MAX = (SLOW_DIV > DIR_SETUP) ? SLOW_DIV : DIR_SETUP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int HW      = $clog2(HOLD_TIMEOUT + 1);

  localparam logic [CW-1:0] SETUP_LD  = CW'(DIR_SETUP - 1);
  localparam logic [CW-1:0] HIGH_LD   = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] LOW_TRIM  = CW'(PULSE_W + 1);
  localparam logic [CW-1:0] FAST_P    = CW'(FAST_DIV);
  localparam logic [CW-1:0] SLOW_P    = CW'(SLOW_DIV);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    Z_HOLD = 2'd0,
    Z_SLOW = 2'd1,
    Z_FAST = 2'd2
  } zone_t;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_IDLE  = 3'd1,
    S_SETUP = 3'd2,
    S_HIGH  = 3'd3,
    S_LOW   = 3'd4,
    S_PARK  = 3'd5
  } state_t;

  // Error is W+1 bits signed so x - x0 never overflows.
  logic signed [W:0] err;
  logic [W:0]        mag;
  zone_t             zone_calc;
  logic              sign_calc;

  assign err       = $signed({1'b0, bus.x}) - $signed({1'b0, bus.x0});
  assign mag       = err[W] ? (-err) : err;
  assign sign_calc = !err[W] && (err != '0);

  always_comb begin
    zone_calc = Z_FAST;
    if (mag < {1'b0, bus.dx1}) begin
      zone_calc = Z_HOLD;
    end else if (mag < {1'b0, bus.dx2}) begin
      zone_calc = Z_SLOW;
    end
  end

  zone_t zone_q;
  logic  sign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zone_q <= Z_HOLD;
      sign_q <= 1'b0;
    end else if (!bus.tr_mode_enable) begin
      zone_q <= Z_HOLD;
    end else if (bus.data_valid) begin
      zone_q <= zone_calc;
      sign_q <= sign_calc;
    end
  end

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [HW-1:0]  hold_cnt, hold_n;
  logic [CW-1:0]  period, period_n;
  logic [CW-1:0]  low_len;
  logic           dir_q, dir_n;
  logic           pulse_q, pulse_n;

  // The IDLE decision cycle counts as one of the period's low cycles.
  assign low_len = period - LOW_TRIM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_OFF;
      cnt      <= '0;
      hold_cnt <= '0;
      period   <= '0;
      dir_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hold_cnt <= hold_n;
      period   <= period_n;
      dir_q    <= dir_n;
      pulse_q  <= pulse_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hold_n   = '0;
    period_n = period;
    dir_n    = dir_q;
    pulse_n  = 1'b0;
    unique case (state)
      S_OFF: begin
        if (bus.tr_mode_enable) begin
          state_n = S_SETUP;
          cnt_n   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (!bus.tr_mode_enable) begin
          state_n = S_OFF;
        end else if (cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_IDLE: begin
        if (!bus.tr_mode_enable) begin
          state_n = S_OFF;
        end else if (zone_q == Z_HOLD) begin
          if (hold_cnt == HOLD_LAST) begin
            state_n = S_PARK;
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end else if (sign_q != dir_q) begin
          dir_n   = sign_q;
          state_n = S_SETUP;
          cnt_n   = SETUP_LD;
        end else begin
          state_n  = S_HIGH;
          cnt_n    = HIGH_LD;
          period_n = (zone_q == Z_FAST) ? FAST_P : SLOW_P;
          pulse_n  = 1'b1;
        end
      end
      S_HIGH: begin
        // A started pulse always runs its full width, even when disabled.
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!bus.tr_mode_enable) begin
          state_n = S_OFF;
        end else if (low_len == '0) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_LOW;
          cnt_n   = low_len - 1'b1;
        end
      end
      S_LOW: begin
        if (!bus.tr_mode_enable) begin
          state_n = S_OFF;
        end else if (cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_PARK: begin
        if (!bus.tr_mode_enable) begin
          state_n = S_OFF;
        end else if (zone_q != Z_HOLD) begin
          state_n = S_SETUP;
          cnt_n   = SETUP_LD;
          dir_n   = sign_q;
        end
      end
      default: begin
        state_n = S_OFF;
      end
    endcase
  end

  assign bus.drv_step      = (state == S_HIGH);
  assign bus.drv_enable_SM = (state != S_OFF) && (state != S_PARK);
  assign bus.busy          = (state == S_SETUP) || (state == S_HIGH) || (state == S_LOW);
  assign bus.drv_dir       = dir_q;
  assign bus.pulse         = pulse_q;
  assign bus.zone          = zone_q;

`ifdef STEP_COUNT_EN
  logic               pos_clear;
  logic signed [31:0] step_pos_q;

  assign pos_clear = (state == S_OFF) && bus.tr_mode_enable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_pos_q <= '0;
    end else if (pos_clear) begin
      step_pos_q <= '0;
    end else if (pulse_n) begin
      step_pos_q <= step_pos_q + (dir_q ? -32'sd1 : 32'sd1);
    end
  end

  assign bus.step_pos = step_pos_q;
`endif

endmodule
